// File: rtl/psum_accum_v2.sv
//------------------------------------------------------------------------------
// Module   : psum_accum_v2
// Summary  : Multi-channel partial-sum accumulator with round/shift/ReLU/saturate
//            requantisation and a valid/ready result stream.
//            Optional build macro PSUM_BIAS_EN adds a latched signed cfg_bias.
// Revision : 2.0 - parametrised multi-channel successor
//------------------------------------------------------------------------------
`default_nettype none

module psum_accum_v2 #(
    parameter int IN_W   = 24,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 132,
    parameter int ADDR_W = 8,
    parameter int CH_W   = 4,
    parameter int SH_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CH_W-1:0]          cfg_num_ch,
    input  logic [ADDR_W:0]          cfg_num_pix,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic                     cfg_relu,
`ifdef PSUM_BIAS_EN
    input  logic signed [ACC_W-1:0]  cfg_bias,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ADDR_W:0]         c_depth   = (ADDR_W+1)'(DEPTH);

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? c_acc_min : c_acc_max;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          num_ch_q, num_ch_d;
    logic [ADDR_W:0]          num_pix_q, num_pix_d;
    logic [SH_W-1:0]          shift_q, shift_d;
    logic                     relu_q, relu_d;
    logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
    logic [ADDR_W:0]          rd_idx_q, rd_idx_d;
    logic                     out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     err_q, err_d;
    logic signed [ACC_W-1:0]  bias_q, bias_d;

    logic signed [ACC_W-1:0]  acc_mem [DEPTH];

    // Write path: single-cycle read-modify-write into the accumulator array
    logic                     accept;
    logic                     addr_ok;
    logic                     wr_en;
    logic [ADDR_W-1:0]        rmw_idx;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  acc_rd;
    logic signed [ACC_W-1:0]  wr_data;
    logic [CH_W-1:0]          last_ch;

    always_comb begin
        accept  = in_valid && (state_q == S_ACCUM);
        addr_ok = ({1'b0, in_addr} < num_pix_q) && ({1'b0, in_addr} < c_depth);
        wr_en   = accept && addr_ok;
        rmw_idx = addr_ok ? in_addr : '0;
        in_ext  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        acc_rd  = acc_mem[rmw_idx];
        wr_data = (ch_cnt_q == '0) ? in_ext : sat_add(acc_rd, in_ext);
        last_ch = (num_ch_q == '0) ? '0 : (num_ch_q - CH_W'(1));
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            acc_mem[rmw_idx] <= wr_data;
    end

    // Requantisation of the pixel addressed by the drain index
    logic [ADDR_W-1:0]        dr_idx;
    logic signed [ACC_W-1:0]  dr_acc;
    logic signed [ACC_W-1:0]  biased;
    logic [ACC_W:0]           rnd;
    logic signed [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    shifted;
    logic signed [ACC_W:0]    clamped;
    logic [OUT_W-1:0]         q_val;

    always_comb begin
        dr_idx  = (rd_idx_q < c_depth) ? rd_idx_q[ADDR_W-1:0] : '0;
        dr_acc  = acc_mem[dr_idx];
        biased  = sat_add(dr_acc, bias_q);
        rnd     = '0;
        if (shift_q != '0)
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_q - SH_W'(1));
        rounded = {biased[ACC_W-1], biased} + rnd;
        shifted = rounded >>> shift_q;
        clamped = (relu_q && shifted[ACC_W]) ? '0 : shifted;
        if (clamped[ACC_W])
            q_val = '0;
        else if (|clamped[ACC_W-1:OUT_W])
            q_val = '1;
        else
            q_val = clamped[OUT_W-1:0];
    end

    // Control: job sequencing, channel counting and output stream
    logic load;

    always_comb begin
        state_d     = state_q;
        num_ch_d    = num_ch_q;
        num_pix_d   = num_pix_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        bias_d      = bias_q;
        ch_cnt_d    = ch_cnt_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_ch_d  = cfg_num_ch;
                    num_pix_d = cfg_num_pix;
                    shift_d   = cfg_shift;
                    relu_d    = cfg_relu;
`ifdef PSUM_BIAS_EN
                    bias_d    = cfg_bias;
`else
                    bias_d    = '0;
`endif
                    ch_cnt_d  = '0;
                    rd_idx_d  = '0;
                    err_d     = 1'b0;
                    state_d   = (cfg_num_pix == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (!addr_ok)
                        err_d = 1'b1;
                    if (in_last) begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                        if (ch_cnt_q == last_ch) begin
                            state_d  = S_DRAIN;
                            rd_idx_d = '0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Refill whenever the output register is empty or being drained
                load = (!out_valid_q || out_ready) && (rd_idx_q < num_pix_q);
                if (load) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = rd_idx_q[ADDR_W-1:0];
                    out_data_d  = q_val;
                    rd_idx_d    = rd_idx_q + (ADDR_W+1)'(1);
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_ch_q    <= '0;
            num_pix_q   <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            ch_cnt_q    <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            num_pix_q   <= num_pix_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            ch_cnt_q    <= ch_cnt_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_accum_v2.sv
// Directed bench for psum_accum_v2: scoreboarded output stream, control and error checks.
`timescale 1ns/1ps
`default_nettype none

module tb_psum_accum_v2;

    localparam int IN_W   = 24;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 132;
    localparam int ADDR_W = 8;
    localparam int CH_W   = 4;
    localparam int SH_W   = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [CH_W-1:0]         cfg_num_ch;
    logic [ADDR_W:0]         cfg_num_pix;
    logic [SH_W-1:0]         cfg_shift;
    logic                    cfg_relu;
`ifdef PSUM_BIAS_EN
    logic signed [ACC_W-1:0] cfg_bias;
`endif
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_W-1:0]       in_addr;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_W-1:0]       out_addr;
    logic [OUT_W-1:0]        out_data;
    logic                    busy;
    logic                    done;
    logic                    err;

    psum_accum_v2 #(
        .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .CH_W(CH_W), .SH_W(SH_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
`ifdef PSUM_BIAS_EN
        .cfg_bias(cfg_bias),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     last_hs_cyc = -1;
    longint model [DEPTH];
    int     job_npix;
    int     job_shift;
    bit     job_relu;
    longint job_bias;
    int     cur_ch;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic int requant(input longint a);
        longint v;
        v = sat32(a + job_bias);
        if (job_shift > 0)
            v = v + (64'sd1 <<< (job_shift - 1));
        v = v >>> job_shift;
        if (job_relu && v < 0) v = 0;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return int'(v);
    endfunction

    // Output monitor: checks stalls hold their beat and pops the scoreboard per handshake
    logic              stall_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [OUT_W-1:0]  prev_data;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, prev_addr);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_addr", out_addr, e.addr);
                    check("out_data", out_data, e.data);
                end
                last_hs_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_addr  = out_addr;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int nch, input int npix, input int shift,
                             input bit relu, input longint bias);
        cfg_num_ch  = CH_W'(nch);
        cfg_num_pix = (ADDR_W+1)'(npix);
        cfg_shift   = SH_W'(shift);
        cfg_relu    = relu;
`ifdef PSUM_BIAS_EN
        cfg_bias    = ACC_W'(bias);
        job_bias    = bias;
`else
        job_bias    = 0;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        job_npix  = npix;
        job_shift = shift;
        job_relu  = relu;
        cur_ch    = 0;
        check("start_busy", busy, 1);
        check("start_err_clear", err, 0);
    endtask

    task automatic send(input int addr, input longint data, input bit last);
        int n;
        in_valid = 1'b1;
        in_addr  = ADDR_W'(addr);
        in_data  = IN_W'(data);
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (addr < job_npix) begin
            if (cur_ch == 0) model[addr] = data;
            else             model[addr] = sat32(model[addr] + data);
        end
        if (last) cur_ch++;
    endtask

    task automatic push_expected();
        for (int i = 0; i < job_npix; i++) begin
            exp_t e;
            e.addr = i;
            e.data = requant(model[i]);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit, input bit toggle, output int dcyc);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n;
        n = 0;
        while (!done && n < limit) begin
            if (toggle) out_ready = pat[n % 4];
            tick();
            n++;
        end
        check("done_seen", done, 1);
        dcyc = cyc;
        out_ready = 1'b1;
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dcyc;
        int n;
        longint d1 [4] = '{5, -3, 300, 7};

        rst = 1'b1; start = 1'b0; cfg_num_ch = '0; cfg_num_pix = '0;
        cfg_shift = '0; cfg_relu = 1'b0;
`ifdef PSUM_BIAS_EN
        cfg_bias = '0;
`endif
        in_valid = 1'b0; in_addr = '0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Single channel, saturation both ways, done one cycle after last handshake
        start_job(1, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(i, d1[i], i == 3);
        push_expected();
        wait_done(40, 0, dcyc);
        check("done_latency", dcyc, last_hs_cyc + 1);

        // Three channels with rounding shift and ReLU; a start while busy is ignored
        start_job(3, 2, 1, 1, 0);
        cfg_num_pix = 1; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            send(0, 10, 0);
            send(1, -4, 1);
        end
        check("model_acc0", model[0], 30);
        push_expected();
        wait_done(40, 0, dcyc);

        // Rounding cases
        start_job(1, 1, 2, 0, 0);
        send(0, 7, 1);
        check("round_model", requant(model[0]), 2);
        push_expected();
        wait_done(40, 0, dcyc);
        start_job(1, 1, 1, 0, 0);
        send(0, -6, 1);
        push_expected();
        wait_done(40, 0, dcyc);

        // Backpressure with ready pattern 1,0,0,1
        start_job(1, 3, 0, 0, 0);
        send(0, 100, 0);
        send(1, -50, 0);
        send(2, 20, 1);
        push_expected();
        wait_done(60, 1, dcyc);

        // Out-of-range beat: sticky err, no write, its in_last still counts
        start_job(2, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(i, i + 1, i == 3);
        for (int i = 0; i < 4; i++) send(i, 1, 0);
        send(200, 99, 1);
        check("err_set", err, 1);
        check("in_ready_after_bad_last", in_ready, 0);
        push_expected();
        wait_done(40, 0, dcyc);
        check("err_sticky", err, 1);

        // Zero pixels: straight to done with no beats (start_job also checks err clear)
        start_job(1, 0, 0, 0, 0);
        wait_done(10, 0, dcyc);

        // Reset mid-drain
        start_job(1, 4, 0, 0, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i, 9, i == 3);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("drain_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done_after_abort", done, 0);
        end

        // Fresh job after the abort
        start_job(1, 2, 0, 0, 0);
        send(0, 42, 0);
        send(1, 255, 1);
        push_expected();
        wait_done(40, 0, dcyc);

`ifdef PSUM_BIAS_EN
        start_job(1, 1, 0, 0, -20);
        send(0, 25, 1);
        check("bias_model", requant(model[0]), 5);
        push_expected();
        wait_done(40, 0, dcyc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
